// File: rtl/dma_job_scheduler.sv
// dma_job_scheduler
// Front-end controller for the NASTI data mover. Takes copy jobs from
// NUM_REQ requesters, picks one round-robin, rejects malformed jobs,
// drives the mover through its en/done handshake under a watchdog and
// returns one completion (id + status) per accepted job.
//
// Handshakes: a transfer on req_* or cpl_* happens on a rising aclk edge
// where valid and ready are both high; valid is held until that edge.
//
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   req_valid/req_ready          per-requester job handshake (ready one-hot or zero)
//   req_src_addr/dest_addr/length  packed job fields, slice i = requester i
//   cpl_valid/cpl_ready          completion handshake
//   cpl_id, cpl_status           requester index, 00 ok / 01 rejected / 10 timeout
//   mv_src_addr/dest_addr/length job fields presented to the mover
//   mv_en, mv_done               one-cycle start pulse, mover idle flag
//   busy                         high whenever the controller is not IDLE
//   dbg_state, dbg_rr_ptr        FSM state and round-robin pointer for observation
module dma_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dest_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_length,
    output logic                          cpl_valid,
    input  logic                          cpl_ready,
    output logic [ID_W-1:0]               cpl_id,
    output logic [1:0]                    cpl_status,
    output logic [ADDR_WIDTH-1:0]         mv_src_addr,
    output logic [ADDR_WIDTH-1:0]         mv_dest_addr,
    output logic [ADDR_WIDTH-1:0]         mv_length,
    output logic                          mv_en,
    input  logic                          mv_done,
    output logic                          busy,
    output logic [2:0]                    dbg_state,
    output logic [ID_W-1:0]               dbg_rr_ptr
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CPL       = 3'd4
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_REJECT  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Expiry is flagged when the counter reaches TIMEOUT_CYCLES-1.
    localparam logic [31:0] WDOG_LIMIT =
        (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t                r_state;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_cpl_id;
    logic [1:0]            r_status;
    logic                  r_cpl_valid;
    logic                  r_mv_en;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_mv_src;
    logic [ADDR_WIDTH-1:0] r_mv_dest;
    logic [ADDR_WIDTH-1:0] r_mv_len;
    logic [31:0]           r_wdog;

    logic                  w_found;
    logic [ID_W-1:0]       w_winner;
    int                    w_idx;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_sel_src;
    logic [ADDR_WIDTH-1:0] w_sel_dest;
    logic [ADDR_WIDTH-1:0] w_sel_len;
    logic                  w_bad;
    logic                  w_expired;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[ID_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
    end

    // A grant needs an idle controller and an idle mover; this also keeps a
    // timed-out mover from being relaunched while it is still running.
    assign w_grant = (r_state == S_IDLE) && mv_done && w_found;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign w_sel_src  = req_src_addr [w_winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_dest = req_dest_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_len  = req_length   [w_winner*ADDR_WIDTH +: ADDR_WIDTH];

    // The mover works in 8-byte beats: everything must be 8-byte aligned.
    assign w_bad = (w_sel_len == '0) || (|w_sel_src[2:0]) ||
                   (|w_sel_dest[2:0]) || (|w_sel_len[2:0]);

    assign w_expired = (TIMEOUT_CYCLES != 0) && (r_wdog >= WDOG_LIMIT);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cpl_id    <= '0;
            r_status    <= ST_OK;
            r_cpl_valid <= 1'b0;
            r_mv_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_mv_src    <= '0;
            r_mv_dest   <= '0;
            r_mv_len    <= '0;
            r_wdog      <= '0;
        end else begin
            r_mv_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_mv_src  <= w_sel_src;
                        r_mv_dest <= w_sel_dest;
                        r_mv_len  <= w_sel_len;
                        r_cpl_id  <= w_winner;
                        r_rr_ptr  <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
                        r_busy    <= 1'b1;
                        if (w_bad) begin
                            r_status    <= ST_REJECT;
                            r_cpl_valid <= 1'b1;
                            r_state     <= S_CPL;
                        end else begin
                            r_mv_en <= 1'b1;
                            r_state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    r_wdog <= r_wdog + 32'd1;
                    // Seeing the mover go busy takes priority over expiry.
                    if (!mv_done) begin
                        r_state <= S_WAIT_DONE;
                    end else if (w_expired) begin
                        r_status    <= ST_TIMEOUT;
                        r_cpl_valid <= 1'b1;
                        r_state     <= S_CPL;
                    end
                end
                S_WAIT_DONE: begin
                    r_wdog <= r_wdog + 32'd1;
                    if (mv_done) begin
                        r_status    <= ST_OK;
                        r_cpl_valid <= 1'b1;
                        r_state     <= S_CPL;
                    end else if (w_expired) begin
                        r_status    <= ST_TIMEOUT;
                        r_cpl_valid <= 1'b1;
                        r_state     <= S_CPL;
                    end
                end
                S_CPL: begin
                    if (cpl_ready) begin
                        r_cpl_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpl_valid    = r_cpl_valid;
    assign cpl_id       = r_cpl_id;
    assign cpl_status   = r_status;
    assign mv_src_addr  = r_mv_src;
    assign mv_dest_addr = r_mv_dest;
    assign mv_length    = r_mv_len;
    assign mv_en        = r_mv_en;
    assign busy         = r_busy;
    assign dbg_state    = r_state;
    assign dbg_rr_ptr   = r_rr_ptr;

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed bench for dma_job_scheduler. Instance a uses the default
// watchdog; instance b uses TIMEOUT_CYCLES=16 for the watchdog cases.
// Inputs change and outputs are sampled just after the falling edge.
module tb_dma_job_scheduler;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int IW = 2;

    // ---------------- clock ----------------
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- instance a (default watchdog) ----------------
    logic            a_areset;
    logic [N-1:0]    a_req_valid;
    logic [N-1:0]    a_req_ready;
    logic [N*AW-1:0] a_req_src;
    logic [N*AW-1:0] a_req_dest;
    logic [N*AW-1:0] a_req_len;
    logic            a_cpl_valid;
    logic            a_cpl_ready;
    logic [IW-1:0]   a_cpl_id;
    logic [1:0]      a_cpl_status;
    logic [AW-1:0]   a_mv_src;
    logic [AW-1:0]   a_mv_dest;
    logic [AW-1:0]   a_mv_len;
    logic            a_mv_en;
    logic            a_mv_done;
    logic            a_busy;
    logic [2:0]      a_dbg_state;
    logic [IW-1:0]   a_dbg_rr;

    dma_job_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut_a (
        .aclk          (aclk),
        .areset        (a_areset),
        .req_valid     (a_req_valid),
        .req_ready     (a_req_ready),
        .req_src_addr  (a_req_src),
        .req_dest_addr (a_req_dest),
        .req_length    (a_req_len),
        .cpl_valid     (a_cpl_valid),
        .cpl_ready     (a_cpl_ready),
        .cpl_id        (a_cpl_id),
        .cpl_status    (a_cpl_status),
        .mv_src_addr   (a_mv_src),
        .mv_dest_addr  (a_mv_dest),
        .mv_length     (a_mv_len),
        .mv_en         (a_mv_en),
        .mv_done       (a_mv_done),
        .busy          (a_busy),
        .dbg_state     (a_dbg_state),
        .dbg_rr_ptr    (a_dbg_rr)
    );

    // ---------------- instance b (TIMEOUT_CYCLES = 16) ----------------
    logic            b_areset;
    logic [N-1:0]    b_req_valid;
    logic [N-1:0]    b_req_ready;
    logic [N*AW-1:0] b_req_src;
    logic [N*AW-1:0] b_req_dest;
    logic [N*AW-1:0] b_req_len;
    logic            b_cpl_valid;
    logic            b_cpl_ready;
    logic [IW-1:0]   b_cpl_id;
    logic [1:0]      b_cpl_status;
    logic [AW-1:0]   b_mv_src;
    logic [AW-1:0]   b_mv_dest;
    logic [AW-1:0]   b_mv_len;
    logic            b_mv_en;
    logic            b_mv_done;
    logic            b_busy;
    logic [2:0]      b_dbg_state;
    logic [IW-1:0]   b_dbg_rr;

    dma_job_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut_b (
        .aclk          (aclk),
        .areset        (b_areset),
        .req_valid     (b_req_valid),
        .req_ready     (b_req_ready),
        .req_src_addr  (b_req_src),
        .req_dest_addr (b_req_dest),
        .req_length    (b_req_len),
        .cpl_valid     (b_cpl_valid),
        .cpl_ready     (b_cpl_ready),
        .cpl_id        (b_cpl_id),
        .cpl_status    (b_cpl_status),
        .mv_src_addr   (b_mv_src),
        .mv_dest_addr  (b_mv_dest),
        .mv_length     (b_mv_len),
        .mv_en         (b_mv_en),
        .mv_done       (b_mv_done),
        .busy          (b_busy),
        .dbg_state     (b_dbg_state),
        .dbg_rr_ptr    (b_dbg_rr)
    );

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    int            a_en_count = 0;
    logic [IW-1:0] exp_q[$];

    always @(posedge aclk) begin
        if (a_mv_en === 1'b1) a_en_count <= a_en_count + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic set_slot_a(input int id, input logic [63:0] src,
                              input logic [63:0] dst, input logic [63:0] len);
        a_req_src [id*AW +: AW] = src;
        a_req_dest[id*AW +: AW] = dst;
        a_req_len [id*AW +: AW] = len;
    endtask

    task automatic set_slot_b(input int id, input logic [63:0] src,
                              input logic [63:0] dst, input logic [63:0] len);
        b_req_src [id*AW +: AW] = src;
        b_req_dest[id*AW +: AW] = dst;
        b_req_len [id*AW +: AW] = len;
    endtask

    task automatic reset_a();
        a_areset = 1'b1;
        step();
        step();
        a_areset = 1'b0;
    endtask

    // Full good job on instance a, entered in IDLE with req_valid already set.
    // The mover model drops done the cycle after en and holds it low lat cycles.
    task automatic job_ok_a(input int id, input logic [63:0] src,
                            input logic [63:0] len, input int lat, input bit drop);
        #1;
        chk("a_grant", 64'(a_req_ready), 64'(1 << id));
        step();
        if (drop) a_req_valid = '0;
        chk("a_launch_en", a_mv_en, 1);
        chk("a_launch_src", a_mv_src, src);
        chk("a_launch_len", a_mv_len, len);
        chk("a_launch_busy", a_busy, 1);
        step();
        a_mv_done = 1'b0;
        chk("a_en_one_cycle", a_mv_en, 0);
        repeat (lat) begin
            step();
            chk("a_cpl_early", a_cpl_valid, 0);
        end
        a_mv_done = 1'b1;
        step();
        chk("a_cpl_valid", a_cpl_valid, 1);
        chk("a_cpl_id", a_cpl_id, id);
        chk("a_cpl_status", a_cpl_status, 2'b00);
        repeat (2) begin
            step();
            chk("a_cpl_hold", a_cpl_valid, 1);
            chk("a_no_grant_in_cpl", a_req_ready, 0);
        end
        a_cpl_ready = 1'b1;
        step();
        a_cpl_ready = 1'b0;
        chk("a_cpl_drop", a_cpl_valid, 0);
        chk("a_back_idle", a_dbg_state, 0);
    endtask

    task automatic reject_a(input int id, input logic [63:0] src,
                            input logic [63:0] dst, input logic [63:0] len);
        set_slot_a(id, src, dst, len);
        a_req_valid = 4'(1 << id);
        #1;
        chk("a_rej_grant", 64'(a_req_ready), 64'(1 << id));
        step();
        a_req_valid = '0;
        chk("a_rej_state", a_dbg_state, 4);
        chk("a_rej_valid", a_cpl_valid, 1);
        chk("a_rej_status", a_cpl_status, 2'b01);
        chk("a_rej_id", a_cpl_id, id);
        chk("a_rej_no_en", a_mv_en, 0);
        a_cpl_ready = 1'b1;
        step();
        a_cpl_ready = 1'b0;
        chk("a_rej_drop", a_cpl_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int en_before;

        a_areset = 1'b1; a_req_valid = '0; a_cpl_ready = 1'b0; a_mv_done = 1'b1;
        a_req_src = '0; a_req_dest = '0; a_req_len = '0;
        b_areset = 1'b1; b_req_valid = '0; b_cpl_ready = 1'b0; b_mv_done = 1'b1;
        b_req_src = '0; b_req_dest = '0; b_req_len = '0;
        step();
        step();

        // reset values
        chk("rst_state", a_dbg_state, 0);
        chk("rst_rr", a_dbg_rr, 0);
        chk("rst_mv_en", a_mv_en, 0);
        chk("rst_cpl_valid", a_cpl_valid, 0);
        chk("rst_cpl_id", a_cpl_id, 0);
        chk("rst_cpl_status", a_cpl_status, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_mv_len", a_mv_len, 0);
        chk("rst_mv_src", a_mv_src, 0);
        a_areset = 1'b0;
        b_areset = 1'b0;
        step();

        // single job on requester 2, other slots carry junk that must be ignored
        set_slot_a(0, 64'h3, 64'h5, 64'h7);
        set_slot_a(2, 64'h1000, 64'h2000, 64'h40);
        a_req_valid = 4'b0100;
        job_ok_a(2, 64'h1000, 64'h40, 20, 1'b1);
        chk("t1_mv_dest", a_mv_dest, 64'h2000);
        chk("t1_rr", a_dbg_rr, 3);
        chk("t1_busy", a_busy, 0);

        // round-robin from rr_ptr=0 with all four requesters valid
        reset_a();
        chk("rr_reset_ptr", a_dbg_rr, 0);
        for (int i = 0; i < N; i++) set_slot_a(i, 64'(32'h100 * (i + 1)), 64'(32'h8000 + 32'h100 * i), 64'h8);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        a_req_valid = 4'b1111;
        while (exp_q.size() > 0) begin
            logic [IW-1:0] e;
            e = exp_q.pop_front();
            job_ok_a(int'(e), 64'(32'h100 * (int'(e) + 1)), 64'h8, 3, 1'b0);
        end
        a_req_valid = '0;
        chk("rr_ptr_after", a_dbg_rr, 1);

        // rejections: zero length, misaligned src, misaligned length
        en_before = a_en_count;
        reject_a(1, 64'h100, 64'h200, 64'h0);
        reject_a(2, 64'h1004, 64'h200, 64'h10);
        reject_a(3, 64'h100, 64'h200, 64'h41);
        chk("rej_no_mv_en", 64'(a_en_count), 64'(en_before));
        chk("rej_rr", a_dbg_rr, 0);

        // reset during WAIT_DONE abandons the job
        set_slot_a(2, 64'h400, 64'h800, 64'h10);
        a_req_valid = 4'b0100;
        #1;
        chk("mid_grant", a_req_ready, 4'b0100);
        step();
        a_req_valid = '0;
        step();
        a_mv_done = 1'b0;
        step();
        chk("mid_wait_done", a_dbg_state, 3);
        chk("mid_rr_before", a_dbg_rr, 3);
        a_areset = 1'b1;
        step();
        a_mv_done = 1'b1;
        chk("mid_state", a_dbg_state, 0);
        chk("mid_mv_en", a_mv_en, 0);
        chk("mid_cpl_valid", a_cpl_valid, 0);
        chk("mid_busy", a_busy, 0);
        chk("mid_rr", a_dbg_rr, 0);
        a_areset = 1'b0;
        repeat (3) begin
            step();
            chk("mid_no_cpl", a_cpl_valid, 0);
        end

        // watchdog expiry on instance b: mover never goes idle again
        set_slot_b(0, 64'h40, 64'h80, 64'h20);
        set_slot_b(1, 64'h140, 64'h180, 64'h10);
        b_req_valid = 4'b0001;
        #1;
        chk("to_grant", b_req_ready, 4'b0001);
        step();
        b_req_valid = '0;
        chk("to_launch_en", b_mv_en, 1);
        step();
        b_mv_done = 1'b0;
        chk("to_wait_busy", b_dbg_state, 2);
        repeat (15) begin
            step();
            chk("to_not_yet", b_cpl_valid, 0);
        end
        step();
        chk("to_cpl_valid", b_cpl_valid, 1);
        chk("to_status", b_cpl_status, 2'b10);
        chk("to_id", b_cpl_id, 0);
        b_req_valid = 4'b0010;
        #1;
        chk("to_no_grant_cpl", b_req_ready, 0);
        b_cpl_ready = 1'b1;
        step();
        b_cpl_ready = 1'b0;
        chk("to_idle_valid", b_cpl_valid, 0);
        repeat (3) begin
            step();
            chk("to_gated_by_done", b_req_ready, 0);
            chk("to_idle_busy", b_busy, 0);
        end
        b_mv_done = 1'b1;
        #1;
        chk("to_regrant", b_req_ready, 4'b0010);

        // watchdog tie: done returns in the expiry cycle, success wins
        step();
        b_req_valid = '0;
        chk("tie_launch_len", b_mv_len, 64'h10);
        step();
        b_mv_done = 1'b0;
        repeat (15) begin
            step();
            chk("tie_not_yet", b_cpl_valid, 0);
        end
        b_mv_done = 1'b1;
        step();
        chk("tie_cpl_valid", b_cpl_valid, 1);
        chk("tie_status", b_cpl_status, 2'b00);
        chk("tie_id", b_cpl_id, 1);
        b_cpl_ready = 1'b1;
        step();
        b_cpl_ready = 1'b0;
        chk("tie_idle", b_dbg_state, 0);
        chk("tie_rr", b_dbg_rr, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
